// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file and its write-back path.
//   WIDTH    : data word width
//   NUM_REGS : architectural register count
//   ADDR_W   : register address width, derived from NUM_REGS
//   reg_addr_t / word_t : register address and data word types
package regfile_pkg;

  localparam int WIDTH    = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]  word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Searches req starting at ptr and wrapping modulo N; the first set bit wins.
//   req       in  N   request vector
//   ptr       in  IW  index searched first
//   grant     out N   one-hot grant (all zero when nothing is requested)
//   grant_idx out IW  index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  // Walk the N candidates in priority order and latch onto the first request.
  // ptr is always < N in practice, so one conditional subtract keeps the
  // candidate index in range.
  always_comb begin
    int   cand;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Shares the register file's single write port among NUM_REQ write-back
// sources with round-robin arbitration, registers the winning write onto the
// register file port, and tracks a pending-write bit per register.
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-low reset
//   req_valid     in   per-requester write pending
//   req_addr      in   per-requester destination register
//   req_data      in   per-requester write data
//   req_ready     out  one-hot grant (combinational)
//   reserve_valid in   issue stage reserves a destination register
//   reserve_addr  in   register being reserved
//   busy          out  pending-write bit per register
//   register_load out  register file write enable
//   address_D     out  register file write address
//   bus_D         out  register file write data
//   wb_error      out  sticky: a write committed to a register not marked busy
module regfile_writeback_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  reg_addr_t [NUM_REQ-1:0]   req_addr,
  input  word_t [NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      reserve_valid,
  input  reg_addr_t                 reserve_addr,
  output logic [NUM_REGS-1:0]       busy,
  output logic                      register_load,
  output reg_addr_t                 address_D,
  output word_t                     bus_D,
  output logic                      wb_error
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]       rr_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic                handshake;
  logic [NUM_REGS-1:0] busy_next;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The arbiter only grants valid requesters, so any grant is a handshake.
  assign req_ready = grant;
  assign handshake = |grant;

  // Pointer moves just past the winner so it gets lowest priority next time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  // Output stage drives the register file directly. Writes to r0 still
  // update address/data but never assert the write enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      register_load <= 1'b0;
      address_D     <= '0;
      bus_D         <= '0;
    end else if (handshake) begin
      register_load <= (req_addr[grant_idx] != '0);
      address_D     <= req_addr[grant_idx];
      bus_D         <= req_data[grant_idx];
    end else begin
      register_load <= 1'b0;
    end
  end

  // Clear on commit first, then apply the reserve so a same-cycle reserve
  // of the committing register leaves it pending. r0 is never pending.
  always_comb begin
    busy_next = busy;
    if (register_load) busy_next[address_D] = 1'b0;
    if (reserve_valid && (reserve_addr != '0)) busy_next[reserve_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= '0;
      wb_error <= 1'b0;
    end else begin
      busy <= busy_next;
      if (register_load && !busy[address_D]) wb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: a behavioural model is
// compared against the DUT every cycle, and directed scenarios pin the model
// with hand-computed values.
module tb_regfile_writeback_arbiter;
  import regfile_pkg::*;

  localparam int NR = 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NR-1:0]        req_valid = '0;
  reg_addr_t [NR-1:0]   req_addr = '0;
  word_t [NR-1:0]       req_data = '0;
  logic [NR-1:0]        req_ready;
  logic                 reserve_valid = 1'b0;
  reg_addr_t            reserve_addr = '0;
  logic [NUM_REGS-1:0]  busy;
  logic                 register_load;
  reg_addr_t            address_D;
  word_t                bus_D;
  logic                 wb_error;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  regfile_writeback_arbiter #(.NUM_REQ(NR)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .reserve_valid (reserve_valid),
    .reserve_addr  (reserve_addr),
    .busy          (busy),
    .register_load (register_load),
    .address_D     (address_D),
    .bus_D         (bus_D),
    .wb_error      (wb_error)
  );

  always #5 clk = ~clk;

  // Model state: what the register file port and scoreboard must hold.
  int                  m_ptr  = 0;
  logic                m_load = 1'b0;
  reg_addr_t           m_addr = '0;
  word_t               m_data = '0;
  logic [NUM_REGS-1:0] m_busy = '0;
  logic                m_err  = 1'b0;

  // Index of the first valid requester searching from ptr, or -1.
  function automatic int model_pick(int ptr, logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] model_grant(int ptr, logic [NR-1:0] v);
    logic [NR-1:0] g;
    int idx;
    g   = '0;
    idx = model_pick(ptr, v);
    if (idx >= 0) g[idx] = 1'b1;
    return g;
  endfunction

  always @(posedge clk or negedge reset) begin
    int                  g;
    logic [NUM_REGS-1:0] nb;
    if (!reset) begin
      m_ptr  <= 0;
      m_load <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      m_busy <= '0;
      m_err  <= 1'b0;
    end else begin
      g  = model_pick(m_ptr, req_valid);
      nb = m_busy;
      if (m_load && !m_busy[m_addr]) m_err <= 1'b1;
      if (m_load) nb[m_addr] = 1'b0;
      if (reserve_valid && reserve_addr != 0) nb[reserve_addr] = 1'b1;
      m_busy <= nb;
      if (g >= 0) begin
        m_addr <= req_addr[g];
        m_data <= req_data[g];
        m_load <= (req_addr[g] != 0);
        m_ptr  <= (g + 1) % NR;
      end else begin
        m_load <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model req_ready", 32'(req_ready), 32'(model_grant(m_ptr, req_valid)));
      checkOutput("model register_load", 32'(register_load), 32'(m_load));
      checkOutput("model address_D", 32'(address_D), 32'(m_addr));
      checkOutput("model bus_D", bus_D, m_data);
      checkOutput("model busy", busy, m_busy);
      checkOutput("model wb_error", 32'(wb_error), 32'(m_err));
    end
  end

  // Advance to a point just after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [NR-1:0] v, input logic rv, input reg_addr_t ra);
    req_valid     = v;
    reserve_valid = rv;
    reserve_addr  = ra;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] seq_addr [4];
    logic [2:0] seq_ready [4];
    seq_addr  = '{5'd5, 5'd6, 5'd7, 5'd5};
    seq_ready = '{3'b010, 3'b100, 3'b001, 3'b010};

    // Reset state
    @(posedge clk);
    check_en = 1'b1;
    tick();
    checkOutput("reset register_load", 32'(register_load), 32'd0);
    checkOutput("reset address_D", 32'(address_D), 32'd0);
    checkOutput("reset bus_D", bus_D, 32'd0);
    checkOutput("reset busy", busy, 32'd0);
    checkOutput("reset wb_error", 32'(wb_error), 32'd0);
    reset = 1'b1;
    applyStimulus(3'b101, 1'b0, '0);
    #1;
    checkOutput("post-reset req_ready 101", 32'(req_ready), 32'b001);
    applyStimulus(3'b000, 1'b0, '0);

    // Reserve r9, requester 1 writes 0xDEADBEEF
    tick();
    applyStimulus(3'b000, 1'b1, 5'd9);
    tick();
    checkOutput("r9 busy after reserve", 32'(busy[9]), 32'd1);
    req_addr[1] = 5'd9;
    req_data[1] = 32'hDEADBEEF;
    applyStimulus(3'b010, 1'b0, '0);
    #1;
    checkOutput("r9 req_ready", 32'(req_ready), 32'b010);
    tick();
    checkOutput("r9 register_load", 32'(register_load), 32'd1);
    checkOutput("r9 bus_D", bus_D, 32'hDEADBEEF);
    checkOutput("r9 address_D", 32'(address_D), 32'd9);
    checkOutput("r9 busy before commit edge", 32'(busy[9]), 32'd1);
    applyStimulus(3'b000, 1'b0, '0);
    tick();
    checkOutput("r9 busy after commit", 32'(busy[9]), 32'd0);
    checkOutput("r9 wb_error", 32'(wb_error), 32'd0);

    // Write to r0 is dropped (pointer is now 2, only requester 0 valid)
    req_addr[0] = 5'd0;
    req_data[0] = 32'h1234;
    applyStimulus(3'b001, 1'b0, '0);
    tick();
    applyStimulus(3'b000, 1'b0, '0);
    checkOutput("r0 register_load", 32'(register_load), 32'd0);
    checkOutput("r0 bus_D", bus_D, 32'h1234);
    checkOutput("r0 busy[0]", 32'(busy[0]), 32'd0);

    // Same-cycle reserve and commit of r3 (pointer is now 1)
    tick();
    applyStimulus(3'b000, 1'b1, 5'd3);
    tick();
    req_addr[2] = 5'd3;
    req_data[2] = 32'h33;
    applyStimulus(3'b100, 1'b0, '0);
    tick();
    checkOutput("r3 register_load", 32'(register_load), 32'd1);
    checkOutput("r3 address_D", 32'(address_D), 32'd3);
    applyStimulus(3'b000, 1'b1, 5'd3);
    tick();
    checkOutput("r3 busy set wins", 32'(busy[3]), 32'd1);
    checkOutput("r3 wb_error", 32'(wb_error), 32'd0);

    // Commit to unreserved r12 (pointer is now 0)
    req_addr[2] = 5'd12;
    req_data[2] = 32'hC;
    applyStimulus(3'b100, 1'b0, '0);
    tick();
    applyStimulus(3'b000, 1'b0, '0);
    checkOutput("r12 register_load", 32'(register_load), 32'd1);
    checkOutput("r12 wb_error before commit edge", 32'(wb_error), 32'd0);
    tick();
    checkOutput("r12 wb_error set", 32'(wb_error), 32'd1);

    // Three requesters held valid: grants 0,1,2,0 (pointer is 0)
    req_addr[0] = 5'd5; req_data[0] = 32'hA0;
    req_addr[1] = 5'd6; req_data[1] = 32'hA1;
    req_addr[2] = 5'd7; req_data[2] = 32'hA2;
    applyStimulus(3'b111, 1'b0, '0);
    #1;
    checkOutput("rr first req_ready", 32'(req_ready), 32'b001);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("rr address_D", 32'(address_D), 32'(seq_addr[k]));
      checkOutput("rr register_load", 32'(register_load), 32'd1);
      checkOutput("rr req_ready", 32'(req_ready), 32'(seq_ready[k]));
      checkOutput("rr wb_error sticky", 32'(wb_error), 32'd1);
    end
    applyStimulus(3'b000, 1'b0, '0);

    // Reset right after a handshake (pointer is now 1)
    tick();
    req_addr[1] = 5'd8;
    req_data[1] = 32'h88;
    applyStimulus(3'b010, 1'b0, '0);
    tick();
    checkOutput("pre-reset register_load", 32'(register_load), 32'd1);
    applyStimulus(3'b000, 1'b0, '0);
    reset = 1'b0;
    #1;
    checkOutput("async reset register_load", 32'(register_load), 32'd0);
    checkOutput("async reset address_D", 32'(address_D), 32'd0);
    checkOutput("async reset bus_D", bus_D, 32'd0);
    tick();
    checkOutput("in-reset register_load", 32'(register_load), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("after reset register_load", 32'(register_load), 32'd0);
    checkOutput("after reset wb_error", 32'(wb_error), 32'd0);
    tick();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
